// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time block RAM loader: FSM states and frame constants.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int HDR_BYTES = 2;
  localparam int CSUM_W    = 8;

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian words from a byte stream; word_valid marks the byte that
// completes a word, with the completed word presented combinationally on word.
module byte_packer #(
  parameter int BYTES = 2,
  parameter int W     = BYTES * 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         byte_en,
  input  logic [7:0]   byte_in,
  output logic [W-1:0] word,
  output logic         word_valid
);

  if (BYTES == 1) begin : g_single
    assign word       = byte_in;
    assign word_valid = byte_en;
  end else begin : g_multi
    localparam int LW = $clog2(BYTES);
    localparam logic [LW-1:0] LAST = LW'(BYTES - 1);

    logic [LW-1:0] lane;
    logic [W-9:0]  low_q;

    // The top lane is never stored: it is the byte arriving on the completing cycle.
    assign word       = {byte_in, low_q};
    assign word_valid = byte_en && (lane == LAST);

    always_ff @(posedge clk) begin
      if (rst || clear) begin
        lane  <= '0;
        low_q <= '0;
      end else if (byte_en) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (lane == LAST) begin
          lane <= '0;
        end else begin
          lane                       <= lane + 1'b1;
          low_q[8*int'(lane) +: 8]   <= byte_in;
        end
      end
    end
  end

endmodule

// File: rtl/bram_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte frame and writes the
// assembled words to consecutive RAM addresses, reporting done or error.
module bram_loader
  import loader_pkg::*;
#(
  parameter int memSize_p   = 8,
  parameter int dataWidth_p = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [7:0]             byte_i,
  input  logic                   byte_valid_i,
  output logic                   byte_ready_o,
  output logic                   mem_write_o,
  output logic [memSize_p-1:0]   mem_addr_o,
  output logic [dataWidth_p-1:0] mem_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   hold_o
);

  localparam int                  BYTES    = dataWidth_p / 8;
  localparam logic [16:0]         DEPTH    = 17'(1) << memSize_p;
  localparam logic [memSize_p-1:0] ADDR_INC = memSize_p'(1);

  state_t             state;
  logic [7:0]         len_lo;
  logic [15:0]        remaining;
  logic [CSUM_W-1:0]  csum;
  logic               xfer;
  logic               accept_start;
  logic [15:0]        n_words;
  logic [dataWidth_p-1:0] word;
  logic               word_valid;

  assign byte_ready_o = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                        (state == S_DATA)   || (state == S_CSUM);
  assign xfer         = byte_valid_i && byte_ready_o;
  assign accept_start = start_i && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign n_words      = {byte_i, len_lo};

  assign busy_o  = byte_ready_o || mem_write_o;
  assign done_o  = (state == S_DONE);
  assign error_o = (state == S_ERR);
  assign hold_o  = !done_o;

  byte_packer #(
    .BYTES (BYTES),
    .W     (dataWidth_p)
  ) u_packer (
    .clk        (clk_i),
    .rst        (rst_i),
    .clear      (accept_start),
    .byte_en    (xfer && (state == S_DATA)),
    .byte_in    (byte_i),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      len_lo      <= '0;
      remaining   <= '0;
      csum        <= '0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
    end else begin
      mem_write_o <= 1'b0;
      // Address advances once each write pulse retires, so the last word of a full RAM wraps it to 0.
      if (mem_write_o) begin
        mem_addr_o <= mem_addr_o + ADDR_INC;
      end

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state      <= S_LEN_LO;
            csum       <= '0;
            mem_addr_o <= '0;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_lo <= byte_i;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            remaining <= n_words;
            if ({1'b0, n_words} > DEPTH) begin
              state <= S_ERR;
            end else if (n_words == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum <= csum + byte_i;
            if (word_valid) begin
              mem_write_o <= 1'b1;
              mem_data_o  <= word;
              remaining   <= remaining - 16'd1;
              if (remaining == 16'd1) begin
                state <= S_CSUM;
              end
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            state <= (byte_i == csum) ? S_DONE : S_ERR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
